hazard_control: RTL and testbench

HAZARD_CONTROL -- requirements
Module: hazard_control

---
 rtl/hazard_control.sv | 120 ++++++++++++
 tb/tb_hazard_control.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control.sv
// hazard_control: pipeline hazard unit for a five-stage in-order core.
// Detects load-use hazards, taken-branch flushes and data-memory waits,
// drives the per-stage enable/flush/bubble controls combinationally, and
// keeps saturating performance counters for stall cycles and flush events.
module hazard_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             ctrl_bubble,
  output logic             exmem_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [1:0]       hz_state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_HOLD     = 2'd3
  } hz_state_e;

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  logic lu;
  logic lu_allowed;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Load-use detection; x0 never carries a real dependency.
  always_comb begin
    lu = idex_memread && (idex_rd != 5'd0) &&
         ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
    // ID/EX already holds a bubble in LU_STALL and FLUSH, so a match there
    // refers to an instruction that is not really in flight.
    lu_allowed = lu && ((state_q == ST_RUN) || (state_q == ST_HOLD));
  end

  // Prioritised control outputs and next state: branch > mem_busy > load-use.
  always_comb begin
    state_d     = ST_RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    ctrl_bubble = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold   = 1'b0;
    if (!rst_n) begin
      // Park the pipeline in a safe all-NOP configuration while in reset.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      ctrl_bubble = 1'b1;
      exmem_flush = 1'b1;
      state_d     = ST_RUN;
    end else if (branch_taken) begin
      // Squash the three wrong-path instructions; PC loads the target.
      ifid_flush  = 1'b1;
      ctrl_bubble = 1'b1;
      exmem_flush = 1'b1;
      state_d     = ST_FLUSH;
    end else if (mem_busy) begin
      // Freeze everything; no bubble since nothing advances.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_hold   = 1'b1;
      state_d     = ST_HOLD;
    end else if (lu_allowed) begin
      // Hold PC and IF/ID for one cycle and insert a bubble into ID/EX.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ctrl_bubble = 1'b1;
      state_d     = ST_LU_STALL;
    end
  end

  // Saturating performance counter next values.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (!pc_write)    stall_cycles_d = sat_inc(stall_cycles_q);
    if (branch_taken) flush_events_d = sat_inc(flush_events_q);
  end

  // State and counter registers; reset aborts any stall or flush in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
  assign hz_state     = state_q;

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: directed scenarios followed by
// randomized traffic, compared against a cycle-level reference model.
module tb_hazard_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       ifid_uses_rs2, idex_memread, branch_taken, mem_busy;

  logic        pc_write, ifid_write, ifid_flush, ctrl_bubble, exmem_flush, pipe_hold;
  logic [15:0] stall_cycles, flush_events;
  logic [1:0]  hz_state;

  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_ctrl_bubble, s_exmem_flush, s_pipe_hold;
  logic [1:0]  s_stall_cycles, s_flush_events;
  logic [1:0]  s_hz_state;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_state;          // 0 run, 1 load-use stall, 2 flush, 3 hold
  int m_stall, m_flush; // unbounded event counts
  int e_next;
  logic [5:0] e_out;    // {pc_write, ifid_write, ifid_flush, ctrl_bubble, exmem_flush, pipe_hold}

  hazard_control u_dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_rd(idex_rd), .idex_memread(idex_memread),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .ctrl_bubble(ctrl_bubble), .exmem_flush(exmem_flush), .pipe_hold(pipe_hold),
    .stall_cycles(stall_cycles), .flush_events(flush_events), .hz_state(hz_state)
  );

  hazard_control #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_rd(idex_rd), .idex_memread(idex_memread),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
    .ctrl_bubble(s_ctrl_bubble), .exmem_flush(s_exmem_flush), .pipe_hold(s_pipe_hold),
    .stall_cycles(s_stall_cycles), .flush_events(s_flush_events), .hz_state(s_hz_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Expected outputs and next state from the current inputs and model state.
  task automatic model_eval();
    logic hazard;
    hazard = idex_memread && idex_rd != 0 &&
             (idex_rd == ifid_rs1 || (ifid_uses_rs2 && idex_rd == ifid_rs2));
    if (!rst_n) begin
      e_out = 6'b001110; e_next = 0;
    end else if (branch_taken) begin
      e_out = 6'b111110; e_next = 2;
    end else if (mem_busy) begin
      e_out = 6'b000001; e_next = 3;
    end else if (hazard && (m_state == 0 || m_state == 3)) begin
      e_out = 6'b000100; e_next = 1;
    end else begin
      e_out = 6'b110000; e_next = 0;
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".state"},      32'(hz_state),       32'(m_state));
    chk({tag, ".stall"},      32'(stall_cycles),   32'(sat(m_stall, 16)));
    chk({tag, ".flush_cnt"},  32'(flush_events),   32'(sat(m_flush, 16)));
    chk({tag, ".s_state"},    32'(s_hz_state),     32'(m_state));
    chk({tag, ".s_stall"},    32'(s_stall_cycles), 32'(sat(m_stall, 2)));
    chk({tag, ".s_flush_cnt"},32'(s_flush_events), 32'(sat(m_flush, 2)));
  endtask

  // Entered at posedge+1 with inputs applied; leaves at the next posedge+1.
  task automatic step(input string tag);
    #3;
    model_eval();
    chk({tag, ".outs"}, 32'({pc_write, ifid_write, ifid_flush, ctrl_bubble, exmem_flush, pipe_hold}),
        32'(e_out));
    chk({tag, ".s_outs"}, 32'({s_pc_write, s_ifid_write, s_ifid_flush, s_ctrl_bubble, s_exmem_flush, s_pipe_hold}),
        32'(e_out));
    @(posedge clk);
    #1;
    if (!e_out[5]) m_stall++;
    if (branch_taken) m_flush++;
    m_state = e_next;
    check_regs(tag);
  endtask

  task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic use2, input logic br, input logic busy);
    idex_memread = mr; idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2;
    ifid_uses_rs2 = use2; branch_taken = br; mem_busy = busy;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    m_state = 0; m_stall = 0; m_flush = 0;

    // Reset state, including with events present while in reset
    #2;
    model_eval();
    chk("reset.outs", 32'({pc_write, ifid_write, ifid_flush, ctrl_bubble, exmem_flush, pipe_hold}), 32'(e_out));
    check_regs("reset");
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    model_eval();
    chk("reset_ev.outs", 32'({pc_write, ifid_write, ifid_flush, ctrl_bubble, exmem_flush, pipe_hold}), 32'(e_out));
    check_regs("reset_ev");
    idle();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Load-use on rs1: one stall cycle, then LU_STALL ignores the lingering match
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0); step("lu_rs1");
    chk("lu_rs1.stall_is_1", 32'(stall_cycles), 32'd1);
    step("lu_rs1_ignored");
    idle(); step("lu_rs1_after");

    // x0 destination never stalls
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); step("x0");

    // rs2 only counts when the instruction reads it
    set_in(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0); step("rs2_unused");
    set_in(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0); step("rs2_used");
    idle(); step("rs2_after");

    // Branch wins over a simultaneous load-use
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0); step("br_lu");
    chk("br_lu.flush_is_1", 32'(flush_events), 32'd1);
    idle(); step("br_after");

    // Three cycles of mem_busy
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1); step("busy3");
    end
    idle(); step("busy3_after");

    // Branch and busy together, busy persists into HOLD, then load-use on exit
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1); step("br_busy");
    set_in(1'b1, 5'd9, 5'd9, 5'd2, 1'b0, 1'b0, 1'b1); step("hold_busy");
    set_in(1'b1, 5'd9, 5'd9, 5'd2, 1'b0, 1'b0, 1'b0); step("hold_exit_lu");
    idle(); step("hold_exit_after");

    // Five consecutive stall cycles for the narrow counter
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1); step("sat5");
    end
    chk("sat5.s_stall_all_ones", 32'(s_stall_cycles), 32'd3);
    idle(); step("sat5_after");

    // Randomized traffic with a small register space to provoke hazards
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 4) == 0));
      step("rand");
    end

    // Reset asserted mid-HOLD takes effect immediately
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1); step("pre_rst_hold");
    rst_n = 1'b0;
    #1;
    m_state = 0; m_stall = 0; m_flush = 0;
    model_eval();
    chk("rst_mid.outs", 32'({pc_write, ifid_write, ifid_flush, ctrl_bubble, exmem_flush, pipe_hold}), 32'(e_out));
    check_regs("rst_mid");
    idle();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(); step("post_rst");
    set_in(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0); step("post_rst_lu");
    idle(); step("post_rst_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
